tx_time_scheduler: RTL and testbench
====================================

TX_TIME_SCHEDULER -- requirements
Module: tx_time_scheduler

Interface
REQ-001 Parameter BITS, default 32, width of sample-clock and timestamp values.
REQ-002 Parameter DEPTH_LOG2, default 2, log2 of the pending-timestamp queue depth (4 entries).
REQ-003 Port clk  input  1  single clock for all logic.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port sample_time  input  BITS  free-running sample-clock counter.
REQ-006 Port ts_push  input  1  enqueue ts_in this cycle.
REQ-007 Port ts_in  input  BITS  packet timestamp; all-ones = send immediately.
REQ-008 Port flush  input  1  synchronous discard of all pending entries.
REQ-009 Port release_req  output  1  head packet is due and awaiting release_ack.
REQ-010 Port release_ts  output  BITS  timestamp of the head entry.
REQ-011 Port release_ack  input  1  consumer accepted the released packet.
REQ-012 Port drop  output  1  one-cycle pulse: head entry expired and was discarded.
REQ-013 Port overflow  output  1  one-cycle pulse: ts_push while full, entry ignored.
REQ-014 Port full, empty  output  1 each  queue status.
REQ-015 Port count  output  DEPTH_LOG2+1  number of queued entries.

Function
REQ-016 Queue SHALL be a FIFO of 2^DEPTH_LOG2 timestamps; a push is visible in count/empty on the next cycle.
REQ-017 delta SHALL be (head - sample_time) modulo 2^BITS; half_range SHALL be 2^(BITS-1)-1, derived from BITS.
REQ-018 Head SHALL be due if head == all-ones or delta == 0; expired if delta > half_range; otherwise waiting.
REQ-019 States SHALL be IDLE, CHECK, RELEASE, DROP.
REQ-020 IDLE -> CHECK when empty == 0; otherwise stay in IDLE.
REQ-021 CHECK: due -> RELEASE; expired -> DROP; waiting -> stay, re-evaluating every cycle.
REQ-022 RELEASE: release_req = 1 and release_ts = head, held stable until release_ack; on ack, pop and go to IDLE; due status is not re-evaluated while in RELEASE.
REQ-023 DROP: drop = 1 for exactly one cycle, pop, then go to IDLE.
REQ-024 Latency: a push into an empty queue with due ts_in at cycle N SHALL give release_req = 1 at N+3.
REQ-025 release_ack outside RELEASE SHALL be ignored.
REQ-026 A simultaneous push and pop SHALL leave count unchanged and never set overflow.
REQ-027 A push while full with a simultaneous pop SHALL be accepted.
REQ-028 A push while full without a pop SHALL be ignored and pulse overflow.
REQ-029 flush SHALL empty the queue and force IDLE next cycle, with priority over push, ack and pop; no release_req or drop results.
REQ-030 Wrap-around: head 0x00000002 with sample_time 0xFFFFFFFE (delta 4) SHALL be waiting, not expired.

Reset
REQ-031 reset SHALL asynchronously force: state IDLE, queue pointers 0, count 0, empty 1, full 0, release_req 0, drop 0, overflow 0, release_ts 0.
REQ-032 Reset asserted mid-RELEASE SHALL discard the pending entry without a drop pulse.

Configuration
REQ-033 Macro TX_SCHED_LATE_COUNT_EN, when defined, SHALL add output late_count [15:0], which increments on each drop pulse, saturates at 0xFFFF, and clears on reset and on flush.
REQ-034 Without TX_SCHED_LATE_COUNT_EN, the late_count port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-035 Exact time: sample_time = 100, push ts 105, ack tied high -> release_req is high for exactly the cycle sample_time == 105, then empty = 1.
REQ-036 Immediate: push 0xFFFFFFFF at cycle N with release_ack low -> release_req high from N+3 and held; ack at N+10 -> pop, count 0.
REQ-037 Late: sample_time = 200, push ts 150 -> a single drop pulse, no release_req, late_count = 1 when the macro is enabled.
REQ-038 Wrap-around: sample_time = 0xFFFFFFF0, push ts 0x00000004 -> release when sample_time wraps to 4, no drop.
REQ-039 Overflow/flush: 5 pushes of future timestamps -> count 4 and one overflow pulse on the fifth; then flush -> count 0, IDLE, no drop.
REQ-040 Reset: assert reset while release_req = 1 -> all outputs reach their reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/tx_time_scheduler.sv
// tx_time_scheduler: FIFO of packet timestamps released to a consumer when
// the free-running sample clock reaches them. Entries that are already in
// the past are dropped. The head is evaluated against sample_time with
// modulo arithmetic, so a counter wrap does not cause false expiry.
// Optional feature macro: TX_SCHED_LATE_COUNT_EN adds the late_count output,
// a saturating count of dropped entries.
module tx_time_scheduler #(
  parameter int unsigned BITS       = 32,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BITS-1:0]     sample_time,
  input  logic                ts_push,
  input  logic [BITS-1:0]     ts_in,
  input  logic                flush,
  output logic                release_req,
  output logic [BITS-1:0]     release_ts,
  input  logic                release_ack,
  output logic                drop,
  output logic                overflow,
  output logic                full,
  output logic                empty,
`ifdef TX_SCHED_LATE_COUNT_EN
  output logic [15:0]         late_count,
`endif
  output logic [DEPTH_LOG2:0] count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  // Largest forward distance still treated as "in the future".
  localparam logic [BITS-1:0] HALF_RANGE = {1'b0, {(BITS-1){1'b1}}};
  localparam logic [BITS-1:0] ALL_ONES   = '1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CHECK   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [1:0] S_DROP    = 2'd3;

  logic [BITS-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_full;
  logic            r_empty;
  logic [1:0]      r_state;
  logic            r_release_req;
  logic [BITS-1:0] r_release_ts;
  logic            r_drop;
  logic            r_overflow;

  logic [1:0]      w_state_nxt;
  logic            w_release_req_nxt;
  logic [BITS-1:0] w_release_ts_nxt;
  logic            w_drop_nxt;
  logic            w_pop;
  logic            w_push_ok;
  logic            w_overflow_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [BITS-1:0] w_head;
  logic [BITS-1:0] w_delta;
  logic            w_due;
  logic            w_expired;

  // Head classification against the current sample clock.
  assign w_head    = r_mem[r_rd_ptr];
  assign w_delta   = w_head - sample_time;
  assign w_due     = (w_head == ALL_ONES) || (w_delta == '0);
  assign w_expired = (w_delta > HALF_RANGE);

  // A push is taken when there is room or the head leaves in the same cycle.
  assign w_push_ok      = ts_push && !flush && (!r_full || w_pop);
  assign w_overflow_nxt = ts_push && !flush && r_full && !w_pop;

  // Next-state and registered-output values for the release scheduler.
  always_comb begin
    w_state_nxt       = r_state;
    w_release_req_nxt = 1'b0;
    w_release_ts_nxt  = r_release_ts;
    w_drop_nxt        = 1'b0;
    w_pop             = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_empty) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (w_due) begin
          w_state_nxt       = S_RELEASE;
          w_release_req_nxt = 1'b1;
          w_release_ts_nxt  = w_head;
        end else if (w_expired) begin
          w_state_nxt = S_DROP;
          w_drop_nxt  = 1'b1;
        end
      end
      S_RELEASE: begin
        if (release_ack) begin
          w_pop       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_release_req_nxt = 1'b1;
        end
      end
      S_DROP: begin
        w_pop       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Flush overrides everything: no pop, no release, no drop.
    if (flush) begin
      w_state_nxt       = S_IDLE;
      w_release_req_nxt = 1'b0;
      w_drop_nxt        = 1'b0;
      w_pop             = 1'b0;
    end
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push_ok && !w_pop)      w_count_nxt = r_count + CW'(1);
    else if (!w_push_ok && w_pop) w_count_nxt = r_count - CW'(1);
  end

  // Scheduler state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Queue pointers, status flags and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_full        <= 1'b0;
      r_empty       <= 1'b1;
      r_release_req <= 1'b0;
      r_release_ts  <= '0;
      r_drop        <= 1'b0;
      r_overflow    <= 1'b0;
    end else if (flush) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_full        <= 1'b0;
      r_empty       <= 1'b1;
      r_release_req <= 1'b0;
      r_drop        <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count       <= w_count_nxt;
      r_full        <= (w_count_nxt == CW'(DEPTH));
      r_empty       <= (w_count_nxt == '0);
      r_release_req <= w_release_req_nxt;
      r_release_ts  <= w_release_ts_nxt;
      r_drop        <= w_drop_nxt;
      r_overflow    <= w_overflow_nxt;
    end
  end

  // Timestamp storage; contents are only read while the entry is valid.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= ts_in;
  end

`ifdef TX_SCHED_LATE_COUNT_EN
  logic [15:0] r_late_count;

  // Saturating count of drop pulses, cleared by flush.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                       r_late_count <= '0;
    else if (flush)                                  r_late_count <= '0;
    else if (w_drop_nxt && (r_late_count != 16'hFFFF)) r_late_count <= r_late_count + 16'd1;
  end

  assign late_count = r_late_count;
`endif

  assign release_req = r_release_req;
  assign release_ts  = r_release_ts;
  assign drop        = r_drop;
  assign overflow    = r_overflow;
  assign full        = r_full;
  assign empty       = r_empty;
  assign count       = r_count;

endmodule

// File: tb/tb_tx_time_scheduler.sv
// Self-checking bench for tx_time_scheduler: scripted vector table,
// corner-case sequences, and a randomized run against a queue-based model.
module tb_tx_time_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sample_time;
  logic        ts_push;
  logic [31:0] ts_in;
  logic        flush;
  logic        release_req;
  logic [31:0] release_ts;
  logic        release_ack;
  logic        drop;
  logic        overflow;
  logic        full;
  logic        empty;
  logic [2:0]  count;
`ifdef TX_SCHED_LATE_COUNT_EN
  logic [15:0] late_count;
`endif

  tx_time_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .sample_time (sample_time),
    .ts_push     (ts_push),
    .ts_in       (ts_in),
    .flush       (flush),
    .release_req (release_req),
    .release_ts  (release_ts),
    .release_ack (release_ack),
    .drop        (drop),
    .overflow    (overflow),
    .full        (full),
    .empty       (empty),
`ifdef TX_SCHED_LATE_COUNT_EN
    .late_count  (late_count),
`endif
    .count       (count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ts_push     = 1'b0;
    ts_in       = 32'd0;
    flush       = 1'b0;
    release_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  // Reference model: FIFO as a queue, head judged with modular distance.
  typedef enum {M_IDLE, M_CHECK, M_REL, M_DROP} mph_t;
  logic [31:0] mq[$];
  mph_t        mph;
  logic        m_req, m_drop, m_ovf;
  logic [31:0] m_ts;
  int          m_late;

  function automatic void model_reset();
    mq.delete();
    mph = M_IDLE; m_req = 1'b0; m_drop = 1'b0; m_ovf = 1'b0; m_ts = 32'd0; m_late = 0;
  endfunction

  function automatic void model_step(input logic push, input logic [31:0] ts,
                                     input logic fl, input logic ack, input logic [31:0] st);
    longint unsigned d;
    logic pop;
    m_ovf  = 1'b0;
    m_drop = 1'b0;
    if (fl) begin
      mq.delete();
      mph = M_IDLE; m_req = 1'b0; m_late = 0;
      return;
    end
    pop = (mph == M_REL && ack) || (mph == M_DROP);
    case (mph)
      M_IDLE:  if (mq.size() != 0) mph = M_CHECK;
      M_CHECK: begin
        d = (64'(mq[0]) + 64'h1_0000_0000 - 64'(st)) % 64'h1_0000_0000;
        if (mq[0] == 32'hFFFF_FFFF || d == 0) begin
          mph = M_REL; m_req = 1'b1; m_ts = mq[0];
        end else if (d > 64'h7FFF_FFFF) begin
          mph = M_DROP; m_drop = 1'b1;
          if (m_late < 65535) m_late++;
        end
      end
      M_REL:   if (ack) begin mph = M_IDLE; m_req = 1'b0; end
      default: mph = M_IDLE;
    endcase
    if (push && mq.size() == 4 && !pop) m_ovf = 1'b1;
    if (pop) void'(mq.pop_front());
    if (push && !m_ovf) mq.push_back(ts);
  endfunction

  typedef struct {
    logic        push;
    logic [31:0] ts;
    logic        fl;
    logic        ack;
    logic [31:0] st;
    int          cnt;
    logic        req;
    logic        drp;
    logic        ovf;
    logic [31:0] rts;
  } vec_t;

  function automatic vec_t mk(input logic p, input logic [31:0] t, input logic f, input logic a,
                              input logic [31:0] s, input int c, input logic r, input logic d,
                              input logic o, input logic [31:0] rt);
    vec_t v;
    v.push = p; v.ts = t; v.fl = f; v.ack = a; v.st = s;
    v.cnt = c; v.req = r; v.drp = d; v.ovf = o; v.rts = rt;
    return v;
  endfunction

  vec_t tbl[25];

  initial begin
    int          n_req;
    int          n_drop;
    logic [31:0] launch;
    logic [31:0] saved;

    // push, ts, flush, ack, sample_time -> count, req, drop, overflow, release_ts
    tbl[0]  = mk(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd1000, 1, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[1]  = mk(1'b0, 32'd0,         1'b0, 1'b0, 32'd1001, 1, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[2]  = mk(1'b0, 32'd0,         1'b0, 1'b0, 32'd1002, 1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
    tbl[3]  = mk(1'b0, 32'd0,         1'b0, 1'b0, 32'd1003, 1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
    tbl[4]  = mk(1'b0, 32'd0,         1'b0, 1'b1, 32'd1004, 0, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[5]  = mk(1'b1, 32'd1010,      1'b0, 1'b0, 32'd1005, 1, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[6]  = mk(1'b1, 32'd1011,      1'b0, 1'b0, 32'd1006, 2, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[7]  = mk(1'b1, 32'd1012,      1'b0, 1'b0, 32'd1007, 3, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[8]  = mk(1'b1, 32'd1013,      1'b0, 1'b0, 32'd1008, 4, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[9]  = mk(1'b1, 32'd1014,      1'b0, 1'b0, 32'd1009, 4, 1'b0, 1'b0, 1'b1, 32'd0);
    tbl[10] = mk(1'b0, 32'd0,         1'b0, 1'b0, 32'd1010, 4, 1'b1, 1'b0, 1'b0, 32'd1010);
    tbl[11] = mk(1'b1, 32'd1020,      1'b0, 1'b1, 32'd1011, 4, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[12] = mk(1'b1, 32'd1030,      1'b1, 1'b1, 32'd1012, 0, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[13] = mk(1'b1, 32'd500,       1'b0, 1'b0, 32'd1013, 1, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[14] = mk(1'b0, 32'd0,         1'b0, 1'b1, 32'd1014, 1, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[15] = mk(1'b0, 32'd0,         1'b0, 1'b0, 32'd1015, 1, 1'b0, 1'b1, 1'b0, 32'd0);
    tbl[16] = mk(1'b0, 32'd0,         1'b0, 1'b0, 32'd1016, 0, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[17] = mk(1'b1, 32'd2,         1'b0, 1'b0, 32'hFFFF_FFFC, 1, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[18] = mk(1'b0, 32'd0,         1'b0, 1'b0, 32'hFFFF_FFFD, 1, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[19] = mk(1'b0, 32'd0,         1'b0, 1'b0, 32'hFFFF_FFFE, 1, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[20] = mk(1'b0, 32'd0,         1'b0, 1'b0, 32'hFFFF_FFFF, 1, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[21] = mk(1'b0, 32'd0,         1'b0, 1'b0, 32'd0,    1, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[22] = mk(1'b0, 32'd0,         1'b0, 1'b0, 32'd1,    1, 1'b0, 1'b0, 1'b0, 32'd0);
    tbl[23] = mk(1'b0, 32'd0,         1'b0, 1'b0, 32'd2,    1, 1'b1, 1'b0, 1'b0, 32'd2);
    tbl[24] = mk(1'b0, 32'd0,         1'b0, 1'b1, 32'd3,    0, 1'b0, 1'b0, 1'b0, 32'd0);

    sample_time = 32'd0;
    do_reset();

    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_req",   32'(release_req), 32'd0);
    chk("rst_drop",  32'(drop), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_ts",    release_ts, 32'd0);

    // Scripted vector table.
    for (int i = 0; i < 25; i++) begin
      ts_push = tbl[i].push; ts_in = tbl[i].ts; flush = tbl[i].fl;
      release_ack = tbl[i].ack; sample_time = tbl[i].st;
      tick();
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("vec%0d_empty", i), 32'(empty), 32'(tbl[i].cnt == 0));
      chk($sformatf("vec%0d_full", i),  32'(full),  32'(tbl[i].cnt == 4));
      chk($sformatf("vec%0d_req", i),   32'(release_req), 32'(tbl[i].req));
      chk($sformatf("vec%0d_drop", i),  32'(drop), 32'(tbl[i].drp));
      chk($sformatf("vec%0d_ovf", i),   32'(overflow), 32'(tbl[i].ovf));
      if (tbl[i].req) chk($sformatf("vec%0d_ts", i), release_ts, tbl[i].rts);
    end
    idle_inputs();

    // Exact time: release decided against sample_time 105, one-cycle request.
    do_reset();
    release_ack = 1'b1;
    sample_time = 32'd100; ts_push = 1'b1; ts_in = 32'd105;
    tick();
    ts_push = 1'b0;
    n_req = 0; launch = 32'd0;
    for (int k = 101; k <= 115; k++) begin
      saved = 32'(k);
      sample_time = saved;
      tick();
      if (release_req) begin n_req++; launch = saved; end
    end
    chk("exact_req_cycles", 32'(n_req), 32'd1);
    chk("exact_launch_st", launch, 32'd105);
    chk("exact_empty", 32'(empty), 32'd1);
    idle_inputs();

    // Immediate: all-ones timestamp, request held until ack at N+10.
    do_reset();
    sample_time = 32'd50; ts_push = 1'b1; ts_in = 32'hFFFF_FFFF;
    tick();
    ts_push = 1'b0;
    tick();
    chk("imm_n2_req", 32'(release_req), 32'd0);
    n_req = 0;
    for (int c = 3; c <= 10; c++) begin
      tick();
      if (release_req) n_req++;
    end
    chk("imm_held_cycles", 32'(n_req), 32'd8);
    chk("imm_ts", release_ts, 32'hFFFF_FFFF);
    release_ack = 1'b1;
    tick();
    release_ack = 1'b0;
    chk("imm_ack_req", 32'(release_req), 32'd0);
    chk("imm_ack_count", 32'(count), 32'd0);

    // Late: timestamp already in the past gives one drop and no release.
    do_reset();
    sample_time = 32'd200; ts_push = 1'b1; ts_in = 32'd150;
    tick();
    ts_push = 1'b0;
    n_req = 0; n_drop = 0;
    for (int k = 0; k < 8; k++) begin
      sample_time = sample_time + 32'd1;
      tick();
      if (release_req) n_req++;
      if (drop) n_drop++;
    end
    chk("late_drops", 32'(n_drop), 32'd1);
    chk("late_reqs", 32'(n_req), 32'd0);
    chk("late_empty", 32'(empty), 32'd1);
`ifdef TX_SCHED_LATE_COUNT_EN
    chk("late_count", 32'(late_count), 32'd1);
`endif

    // Wrap-around: sample_time crosses zero before the timestamp is due.
    do_reset();
    release_ack = 1'b1;
    sample_time = 32'hFFFF_FFF0; ts_push = 1'b1; ts_in = 32'd4;
    tick();
    ts_push = 1'b0;
    n_req = 0; n_drop = 0; launch = 32'd0;
    for (int k = 0; k < 40; k++) begin
      saved = sample_time + 32'd1;
      sample_time = saved;
      tick();
      if (release_req) begin n_req++; launch = saved; end
      if (drop) n_drop++;
    end
    chk("wrap_reqs", 32'(n_req), 32'd1);
    chk("wrap_launch_st", launch, 32'd4);
    chk("wrap_drops", 32'(n_drop), 32'd0);
    idle_inputs();

    // Asynchronous reset while a release is pending.
    do_reset();
    ts_push = 1'b1; ts_in = 32'hFFFF_FFFF;
    tick();
    ts_push = 1'b0;
    tick(); tick();
    chk("arst_pre_req", 32'(release_req), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_req",   32'(release_req), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full",  32'(full), 32'd0);
    chk("arst_drop",  32'(drop), 32'd0);
    chk("arst_ovf",   32'(overflow), 32'd0);
    chk("arst_ts",    release_ts, 32'd0);
    tick();
    reset = 1'b0;
    n_drop = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (drop || release_req) n_drop++;
    end
    chk("arst_after_quiet", 32'(n_drop), 32'd0);
    chk("arst_after_empty", 32'(empty), 32'd1);

    // Randomized run against the reference model, crossing a counter wrap.
    do_reset();
    model_reset();
    sample_time = 32'hFFFF_FA00;
    for (int c = 0; c < 3000; c++) begin
      logic        p, f, a;
      logic [31:0] t;
      p = ($urandom_range(0, 99) < 40);
      f = ($urandom_range(0, 99) < 2);
      a = ($urandom_range(0, 99) < 50);
      if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFFF;
      else t = sample_time + 32'($urandom_range(0, 14)) - 32'd4;
      ts_push = p; ts_in = t; flush = f; release_ack = a;
      model_step(p, t, f, a, sample_time);
      tick();
      chk("rnd_count", 32'(count), 32'(mq.size()));
      chk("rnd_empty", 32'(empty), 32'(mq.size() == 0));
      chk("rnd_full",  32'(full),  32'(mq.size() == 4));
      chk("rnd_req",   32'(release_req), 32'(m_req));
      chk("rnd_drop",  32'(drop), 32'(m_drop));
      chk("rnd_ovf",   32'(overflow), 32'(m_ovf));
      if (m_req) chk("rnd_ts", release_ts, m_ts);
`ifdef TX_SCHED_LATE_COUNT_EN
      chk("rnd_late", 32'(late_count), 32'(m_late));
`endif
      sample_time = sample_time + 32'd1;
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
